store_write_buffer: RTL
=======================

# store_write_buffer

Downstream stage of the store controller. Each cycle the controller asserts its memory-write strobe with a row address, this block captures the four cores' result words for that row into a small FIFO. It then drains each entry to data memory as four single-word writes over a ready/valid handshake, so the store sequence never stalls on data-memory backpressure until the buffer fills.

## Interface
Parameters:
- DATA_W, 8, width of one core result word / data-memory word
- ROW_W, 4, width of the register row address
- DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sw_en  in  1  switch enable from store controller; captures ignored while low
- mem_wr  in  1  memory-write strobe from store controller; one row per high cycle
- row_addr  in  ROW_W  register row being stored, valid with mem_wr
- core_data0..core_data3  in  DATA_W each  result word of core 0..3 for row_addr
- dmem_ready  in  1  data memory accepts the presented word this cycle
- dmem_we  out  1  write request to data memory
- dmem_addr  out  ROW_W+2  word address = {row, core index}
- dmem_wdata  out  DATA_W  word being written
- full  out  1  FIFO holds DEPTH entries
- busy  out  1  FIFO non-empty
- drained  out  1  one-cycle pulse when last pending word is accepted
- overflow  out  1  sticky; a capture was dropped because FIFO was full

## Operation
- Capture: on edge where sw_en && mem_wr && !full, push entry {row_addr, core_data0..3}. Inputs sampled on that edge only.
- sw_en && mem_wr && full: entry dropped, overflow set; cleared only by reset.
- full is evaluated from pre-edge occupancy: push rejected when full even if a pop happens the same edge.
- Drain FSM, states IDLE and WRITE, plus 2-bit core index idx:
  - IDLE: dmem_we=0, dmem_addr=0, dmem_wdata=0. Go to WRITE with idx=0 when FIFO non-empty.
  - WRITE: dmem_we=1, dmem_addr={head.row, idx}, dmem_wdata=head.data[idx]. On dmem_ready, idx increments; on dmem_ready with idx=3, head entry popped, idx=0; stay in WRITE if entries remain after pop (including a simultaneous push), else IDLE.
  - Without dmem_ready, addr/data/we held stable.
- drained=1 on the edge where pop leaves occupancy 0 with no simultaneous push.
- Simultaneous push and pop on non-full FIFO: both happen; occupancy unchanged.
- Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- Reset mid-drain: FIFO emptied, FSM to IDLE, idx=0, words not yet accepted are lost.

## Timing
- Reset values: dmem_we 0, dmem_addr 0, dmem_wdata 0, full 0, busy 0, drained 0, overflow 0.
- dmem_* outputs, full, busy, drained, overflow registered (no combinational path from inputs).
- Latency: capture on edge N → dmem_we high in cycle N+1 when FIFO was empty.
- Drain throughput: one word per cycle with dmem_ready held high; four cycles per row; no bubble between consecutive entries.
- busy/full reflect occupancy after the edge.

## Structure
- Shared package store_pkg: NUM_CORES=4, CORE_IDX_W=2, packed typedef store_entry_t {row, data[NUM_CORES]}; drain state enum.
- Sub-module store_fifo: synchronous DEPTH-entry FIFO of store_entry_t with push/pop/full/empty/count; drain FSM and output registers in the top.

## Test plan
- Single row: mem_wr, sw_en, row_addr=5, data 0x11/0x22/0x33/0x44, dmem_ready=1 → writes addr 0x14..0x17 with 0x11..0x44 on consecutive cycles starting N+1, drained pulses with the last.
- Backpressure: dmem_ready toggled 1,0,0,1… → each word held stable while low, no word skipped or duplicated.
- Burst of 6 rows with dmem_ready=0, DEPTH=4 → full after 4, overflow set, rows 0–3 written in order after ready rises, rows 4–5 never written.
- Push during pop of last word of a full FIFO → push rejected, overflow set. Push during pop with 2 entries → accepted, no bubble, no drained pulse.
- sw_en=0 with mem_wr=1 → nothing captured, busy stays 0.
- rst_n low mid-drain (idx=2) → all outputs zero immediately, FIFO empty. After release, a new row drains from idx 0.

Source files
------------

// File: rtl/store_pkg.sv
// Shared types for the store write buffer: entry layout and drain states.
package store_pkg;

  localparam int NUM_CORES    = 4;
  localparam int CORE_IDX_W   = 2;
  localparam int STORE_DATA_W = 8;
  localparam int STORE_ROW_W  = 4;

  typedef struct packed {
    logic [STORE_ROW_W-1:0] row;
    logic [NUM_CORES-1:0][STORE_DATA_W-1:0] data;
  } store_entry_t;

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } drain_state_t;

endpackage

// File: rtl/store_fifo.sv
// DEPTH-entry FIFO of store entries; exposes the entry that will be
// at the head after the coming edge so the drain outputs can be registered.
module store_fifo
  import store_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  store_entry_t din,
  output store_entry_t head_next,
  output logic         full,
  output logic         empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  store_entry_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0] count_n;

  assign rd_ptr_inc = rd_ptr + PTR_W'(1);

  always_comb begin
    count_n = count;
    unique case ({push, pop})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase
  end

  // With one entry left a pop hands the head over to the word being pushed.
  always_comb begin
    head_next = mem[rd_ptr];
    if (pop) begin
      if (count > CNT_W'(1))
        head_next = mem[rd_ptr_inc];
      else
        head_next = din;
    end else if (count == '0) begin
      head_next = din;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr_inc;
      count <= count_n;
      full  <= (count_n == CNT_W'(DEPTH));
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Captures four core result words per stored row and drains them to
// data memory one word at a time over a ready/valid handshake.
module store_write_buffer
  import store_pkg::*;
#(
  parameter int DATA_W = STORE_DATA_W,
  parameter int ROW_W  = STORE_ROW_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw_en,
  input  logic              mem_wr,
  input  logic [ROW_W-1:0]  row_addr,
  input  logic [DATA_W-1:0] core_data0,
  input  logic [DATA_W-1:0] core_data1,
  input  logic [DATA_W-1:0] core_data2,
  input  logic [DATA_W-1:0] core_data3,
  input  logic              dmem_ready,
  output logic              dmem_we,
  output logic [ROW_W+1:0]  dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              full,
  output logic              busy,
  output logic              drained,
  output logic              overflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  store_entry_t din;
  store_entry_t head_next;
  logic push;
  logic pop;
  logic drop;
  logic drain_last;
  logic fifo_empty;
  logic [CNT_W-1:0] count;

  drain_state_t state;
  drain_state_t state_n;
  logic [CORE_IDX_W-1:0] idx;
  logic [CORE_IDX_W-1:0] idx_n;

  assign din.row  = row_addr;
  assign din.data = {core_data3, core_data2,
                     core_data1, core_data0};

  // full is the pre-edge occupancy, so a pop cannot make room this edge.
  assign push = sw_en && mem_wr && !full;
  assign drop = sw_en && mem_wr && full;
  assign pop  = (state == S_WRITE) && dmem_ready
             && (idx == CORE_IDX_W'(NUM_CORES - 1));
  assign drain_last = pop && (count == CNT_W'(1)) && !push;
  assign busy = ~fifo_empty;

  store_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .din       (din),
    .head_next (head_next),
    .full      (full),
    .empty     (fifo_empty),
    .count     (count)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      S_IDLE: begin
        if (push) begin
          state_n = S_WRITE;
          idx_n   = '0;
        end
      end
      S_WRITE: begin
        if (dmem_ready) begin
          idx_n = idx + CORE_IDX_W'(1);
          if (drain_last)
            state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      drained    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      drained <= drain_last;
      if (drop)
        overflow <= 1'b1;
      if (state_n == S_WRITE) begin
        dmem_we    <= 1'b1;
        dmem_addr  <= {head_next.row, idx_n};
        dmem_wdata <= head_next.data[idx_n];
      end else begin
        dmem_we    <= 1'b0;
        dmem_addr  <= '0;
        dmem_wdata <= '0;
      end
    end
  end

endmodule
